// File: rtl/window_reader_pkg.sv
// -----------------------------------------------------------------------------
// window_reader_pkg
//   Constants and types shared by the blur line-buffer path (window_reader and
//   the convolution stage that consumes its 3x3 windows).
//   - KERNEL_SIZE  : window edge length (3x3 kernel)
//   - NUM_LINES    : number of circular line RAMs
//   - rd_state_t   : read-side FSM states
//   - window_width : packed width of one window for a given pixel width
// -----------------------------------------------------------------------------
package window_reader_pkg;

    localparam int KERNEL_SIZE = 3;
    localparam int NUM_LINES   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    function automatic int window_width(input int data_width);
        return KERNEL_SIZE * KERNEL_SIZE * data_width;
    endfunction

endpackage

// File: rtl/window_reader_line_ram.sv
// -----------------------------------------------------------------------------
// window_reader_line_ram
//   One line of pixel storage: simple dual-port RAM with a write port and a
//   registered read port. A read returns KERNEL_SIZE horizontally adjacent
//   pixels starting at rd_addr, leftmost pixel in the most significant slot,
//   so one access yields a full window row.
//   Ports:
//     clk              rising-edge clock
//     rst              synchronous active-high reset (read register only)
//     wr_en/addr/data  write port, one pixel per cycle
//     rd_en/addr       read request; rd_addr must not exceed depth-KERNEL_SIZE
//     rd_data          registered row, valid the cycle after rd_en; holds
//                      its value while rd_en is low
// -----------------------------------------------------------------------------
module window_reader_line_ram
    import window_reader_pkg::*;
#(
    parameter  int data_width = 8,
    parameter  int depth      = 512,
    localparam int addr_width = $clog2(depth)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [addr_width-1:0]             wr_addr,
    input  logic [data_width-1:0]             wr_data,
    input  logic                              rd_en,
    input  logic [addr_width-1:0]             rd_addr,
    output logic [KERNEL_SIZE*data_width-1:0] rd_data
);

    logic [data_width-1:0] mem [depth];

    // NOTE: the storage array has no reset; its contents are don't-care after
    // reset and a reset term would prevent mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                rd_data[(KERNEL_SIZE-1-k)*data_width +: data_width] <= mem[rd_addr + addr_width'(k)];
            end
        end
    end

endmodule

// File: rtl/window_reader.sv
// -----------------------------------------------------------------------------
// window_reader
//   Read side of the blur line buffer. Stores a raster pixel stream into four
//   circular line RAMs; once three full lines are held and downstream grants a
//   line, reads them back in parallel and emits one 3x3 window per cycle
//   (imageWidth-2 windows per line), then retires the oldest line.
//   Ports:
//     i_clk                rising-edge clock
//     i_rst                synchronous active-high reset
//     i_pixel_data/_valid  incoming raster pixel and qualifier
//     i_window_ready       grant for one line read, sampled only while idle
//     o_window_data        3x3 window, top row in the MS bits, leftmost pixel
//                          most significant within a row; holds when not valid
//     o_window_data_valid  window qualifier
//     o_line_done          pulse with the last window of a line read
//     o_overflow           pulse when a pixel was dropped (all lines full)
// -----------------------------------------------------------------------------
module window_reader
    import window_reader_pkg::*;
#(
    parameter int dataWidth  = 8,
    parameter int imageWidth = 512
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [dataWidth-1:0]                i_pixel_data,
    input  logic                                i_pixel_data_valid,
    input  logic                                i_window_ready,
    output logic [window_width(dataWidth)-1:0]  o_window_data,
    output logic                                o_window_data_valid,
    output logic                                o_line_done,
    output logic                                o_overflow
);

    localparam int COL_WIDTH = $clog2(imageWidth);
    localparam int ROW_WIDTH = KERNEL_SIZE * dataWidth;
    localparam logic [COL_WIDTH-1:0] WR_COL_LAST = COL_WIDTH'(imageWidth - 1);
    localparam logic [COL_WIDTH-1:0] RD_COL_LAST = COL_WIDTH'(imageWidth - KERNEL_SIZE);
    localparam logic [2:0] FULL_COUNT  = 3'(NUM_LINES);
    localparam logic [2:0] READY_COUNT = 3'(KERNEL_SIZE);

    logic [COL_WIDTH-1:0] wr_col;
    logic [COL_WIDTH-1:0] rd_col;
    logic [1:0]           wr_line;
    logic [1:0]           rd_line;
    logic [1:0]           sel_line;      // top line of the window currently on the RAM outputs
    logic [2:0]           lines_filled;
    rd_state_t            state;

    logic full;
    logic accept;
    logic line_complete;
    logic rd_en;
    logic read_end;

    logic [ROW_WIDTH-1:0] ram_rd [NUM_LINES];

    assign full          = (lines_filled == FULL_COUNT);
    assign accept        = i_pixel_data_valid && !full;
    assign line_complete = accept && (wr_col == WR_COL_LAST);
    assign rd_en         = (state == READ);
    assign read_end      = rd_en && (rd_col == RD_COL_LAST);

    // All RAMs read the same column; only the three selected lines are used.
    // The line being written is never among them because writes stop when
    // all four lines are occupied.
    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        window_reader_line_ram #(
            .data_width (dataWidth),
            .depth      (imageWidth)
        ) u_ram (
            .clk     (i_clk),
            .rst     (i_rst),
            .wr_en   (accept && (wr_line == 2'(i))),
            .wr_addr (wr_col),
            .wr_data (i_pixel_data),
            .rd_en   (rd_en),
            .rd_addr (rd_col),
            .rd_data (ram_rd[i])
        );
    end

    // Write side and line occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_col       <= '0;
            wr_line      <= '0;
            lines_filled <= '0;
            o_overflow   <= 1'b0;
        end else begin
            o_overflow <= i_pixel_data_valid && full;
            if (accept) begin
                if (wr_col == WR_COL_LAST) begin
                    wr_col  <= '0;
                    wr_line <= wr_line + 2'd1;
                end else begin
                    wr_col <= wr_col + COL_WIDTH'(1);
                end
            end
            // A line completing and a line retiring together cancel out.
            case ({line_complete, read_end})
                2'b10:   lines_filled <= lines_filled + 3'd1;
                2'b01:   lines_filled <= lines_filled - 3'd1;
                default: ;
            endcase
        end
    end

    // Read FSM with registered window qualifier and line-done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= IDLE;
            rd_col              <= '0;
            rd_line             <= '0;
            sel_line            <= '0;
            o_window_data_valid <= 1'b0;
            o_line_done         <= 1'b0;
        end else begin
            o_window_data_valid <= rd_en;
            o_line_done         <= read_end;
            case (state)
                IDLE: begin
                    if ((lines_filled >= READY_COUNT) && i_window_ready) begin
                        state  <= READ;
                        rd_col <= '0;
                    end
                end
                READ: begin
                    // Captured alongside the RAM read so the output mux only
                    // changes when new window data arrives.
                    sel_line <= rd_line;
                    if (rd_col == RD_COL_LAST) begin
                        state   <= IDLE;
                        rd_line <= rd_line + 2'd1;
                    end else begin
                        rd_col <= rd_col + COL_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Window assembly: top/mid/bot rows come from consecutive lines mod 4.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        o_window_data = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            o_window_data[(KERNEL_SIZE-1-k)*ROW_WIDTH +: ROW_WIDTH] = ram_rd[sel_line + 2'(k)];
        end
    end

endmodule

// File: tb/tb_window_reader.sv
// -----------------------------------------------------------------------------
// tb_window_reader
//   Directed scenarios plus a randomized stream for window_reader with
//   imageWidth = 8, dataWidth = 8. A queue-of-lines reference model predicts
//   every output on every cycle; scenario-level results are also compared to
//   hand-derived constants.
// -----------------------------------------------------------------------------
module tb_window_reader;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int WW = 9 * DW;
    localparam int LW = IW * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pix;
    logic          pvalid;
    logic          ready;
    logic [WW-1:0] wdata;
    logic          wvalid;
    logic          ldone;
    logic          ovf;

    always #5 clk = ~clk;

    window_reader #(
        .dataWidth  (DW),
        .imageWidth (IW)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_pixel_data        (pix),
        .i_pixel_data_valid  (pvalid),
        .i_window_ready      (ready),
        .o_window_data       (wdata),
        .o_window_data_valid (wvalid),
        .o_line_done         (ldone),
        .o_overflow          (ovf)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: complete lines held in arrival order, the line being
    // filled, and the progress of the current line read.
    logic [LW-1:0] m_lines[$];
    logic [LW-1:0] m_cur;
    int            m_col     = 0;
    bit            m_reading = 0;
    int            m_k       = 0;
    logic [WW-1:0] m_data    = '0;

    // Observation statistics per scenario.
    string         phase = "init";
    int            cyc_n = 0;
    int            n_windows, n_done, n_ovf;
    logic [WW-1:0] first_win, last_win;
    int            done_at;
    bit            prev_valid = 0;
    int            tops[$];
    int            start_cyc[$];
    int            done_cyc[$];

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] px(input logic [LW-1:0] line, input int c);
        return line[c*DW +: DW];
    endfunction

    task automatic clear_stats();
        n_windows = 0;
        n_done    = 0;
        n_ovf     = 0;
        done_at   = 0;
        first_win = '0;
        last_win  = '0;
        tops.delete();
        start_cyc.delete();
        done_cyc.delete();
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, then
    // compare every output against the model.
    task automatic cyc(input bit r, input bit v, input logic [DW-1:0] p, input bit rd);
        bit full, can_start, e_valid, e_done, e_ovf;
        rst    = r;
        pvalid = v;
        pix    = p;
        ready  = rd;
        @(posedge clk);
        full      = (m_lines.size() == 4);
        can_start = !m_reading && (m_lines.size() >= 3) && rd;
        e_valid   = 0;
        e_done    = 0;
        e_ovf     = 0;
        if (r) begin
            m_lines.delete();
            m_col     = 0;
            m_reading = 0;
            m_data    = '0;
        end else begin
            e_ovf = v && full;
            if (m_reading) begin
                e_valid = 1;
                for (int row = 0; row < 3; row++) begin
                    for (int j = 0; j < 3; j++) begin
                        m_data[(8 - (row*3 + j))*DW +: DW] = px(m_lines[row], m_k + j);
                    end
                end
                if (m_k == IW - 3) e_done = 1;
                else m_k++;
            end
            if (e_done) begin
                m_reading = 0;
                void'(m_lines.pop_front());
            end
            if (v && !full) begin
                m_cur[m_col*DW +: DW] = p;
                if (m_col == IW - 1) begin
                    m_lines.push_back(m_cur);
                    m_col = 0;
                end else begin
                    m_col++;
                end
            end
            if (can_start) begin
                m_reading = 1;
                m_k       = 0;
            end
        end
        #1;
        cyc_n++;
        check({phase, "/valid"},     WW'(wvalid), WW'(e_valid));
        check({phase, "/line_done"}, WW'(ldone),  WW'(e_done));
        check({phase, "/overflow"},  WW'(ovf),    WW'(e_ovf));
        check({phase, "/window"},    wdata,       m_data);
        if (wvalid) begin
            n_windows++;
            if (n_windows == 1) first_win = wdata;
            last_win = wdata;
            if (!prev_valid) begin
                tops.push_back(int'(wdata[WW-1 -: DW]) >> 4);
                start_cyc.push_back(cyc_n);
            end
        end
        if (ldone) begin
            n_done++;
            done_at = n_windows;
            done_cyc.push_back(cyc_n);
        end
        if (ovf) n_ovf++;
        prev_valid = wvalid;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, '0, 1'b0);
        clear_stats();
    endtask

    task automatic write_row(input int row, input bit rd);
        for (int c = 0; c < IW; c++) cyc(1'b0, 1'b1, DW'(row*16 + c), rd);
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, rd);
    endtask

    int row3_end;

    initial begin
        rst    = 1'b0;
        pix    = '0;
        pvalid = 1'b0;
        ready  = 1'b0;
        clear_stats();

        // 1: reset with random inputs, then no window before three lines.
        phase = "reset";
        cyc(1'b1, 1'($urandom_range(1)), DW'($urandom), 1'($urandom_range(1)));
        check("reset/data_zero", wdata, '0);
        clear_stats();
        phase = "two_lines";
        write_row(0, 1'b1);
        write_row(1, 1'b1);
        idle(6, 1'b1);
        check("two_lines/no_window", n_windows, 0);

        // 2: first read of rows 0..2.
        phase = "first_read";
        do_reset();
        for (int r = 0; r < 3; r++) write_row(r, 1'b1);
        idle(12, 1'b1);
        check("first_read/count", n_windows, 6);
        check("first_read/first", first_win, 72'h00_01_02_10_11_12_20_21_22);
        check("first_read/last",  last_win,  72'h05_06_07_15_16_17_25_26_27);
        check("first_read/done_at_6th", done_at, 6);
        check("first_read/done_count", n_done, 1);

        // 3: continuous streaming of rows 0..5 with ready high.
        phase = "streaming";
        do_reset();
        for (int r = 0; r < 6; r++) write_row(r, 1'b1);
        idle(40, 1'b1);
        check("streaming/phases", tops.size(), 4);
        for (int i = 0; i < 4; i++) check("streaming/top_row", (tops.size() > i) ? tops[i] : 255, i);
        check("streaming/no_overflow", n_ovf, 0);

        // 4: backpressure until full, then release.
        phase = "backpressure";
        do_reset();
        for (int r = 0; r < 5; r++) write_row(r, 1'b0);
        check("backpressure/overflow_pulses", n_ovf, 8);
        check("backpressure/no_window", n_windows, 0);
        idle(30, 1'b1);
        check("backpressure/phases", tops.size(), 2);
        for (int i = 0; i < 2; i++) check("backpressure/top_row", (tops.size() > i) ? tops[i] : 255, i);
        check("backpressure/windows", n_windows, 12);

        // 5: row 3 completes on the same cycle as the read of rows 0..2 ends.
        phase = "simultaneous";
        do_reset();
        for (int r = 0; r < 3; r++) write_row(r, 1'b0);
        for (int c = 0; c < IW; c++) cyc(1'b0, 1'b1, DW'(3*16 + c), c != 0);
        row3_end = cyc_n;
        idle(20, 1'b1);
        check("simultaneous/phases", tops.size(), 2);
        for (int i = 0; i < 2; i++) check("simultaneous/top_row", (tops.size() > i) ? tops[i] : 255, i);
        check("simultaneous/coincide", (done_cyc.size() > 0) ? done_cyc[0] : -1, row3_end);
        check("simultaneous/gap",
              (start_cyc.size() > 1 && done_cyc.size() > 0) ? start_cyc[1] - done_cyc[0] : -1, 2);

        // 6: reset during the third window, then refill.
        phase = "reset_mid_read";
        do_reset();
        for (int r = 0; r < 3; r++) write_row(r, 1'b1);
        for (int i = 0; i < 40 && n_windows < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1);
        check("reset_mid_read/reached_3rd", n_windows, 3);
        cyc(1'b1, 1'b0, '0, 1'b1);
        check("reset_mid_read/valid_low", WW'(wvalid), '0);
        clear_stats();
        for (int r = 3; r < 6; r++) write_row(r, 1'b1);
        idle(12, 1'b1);
        check("reset_mid_read/count", n_windows, 6);
        check("reset_mid_read/first", first_win, 72'h30_31_32_40_41_42_50_51_52);

        // Randomized traffic with occasional resets, fully model-checked.
        phase = "random";
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(99) == 0, $urandom_range(3) != 0, DW'($urandom), 1'($urandom_range(1)));
        end
        idle(20, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
